// File: rtl/div_ctrl.sv
// Sequencing controller between the execute stage and the signed/unsigned divider IPs.
// Latches one request, handshakes operands into the selected IP, returns the result with a done pulse.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   src_dividend,
  input  logic [WIDTH-1:0]   src_divisor,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [WIDTH-1:0]   div_divisor_data,
  output logic [WIDTH-1:0]   div_dividend_data,
  output logic               div_divisor_valid,
  output logic               div_dividend_valid,
  input  logic               div_divisor_ready,
  input  logic               div_dividend_ready,
  input  logic               div_dout_valid,
  input  logic [2*WIDTH-1:0] div_dout_data,
  output logic [WIDTH-1:0]   divu_divisor_data,
  output logic [WIDTH-1:0]   divu_dividend_data,
  output logic               divu_divisor_valid,
  output logic               divu_dividend_valid,
  input  logic               divu_divisor_ready,
  input  logic               divu_dividend_ready,
  input  logic               divu_dout_valid,
  input  logic [2*WIDTH-1:0] divu_dout_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               divisor_valid_q, divisor_valid_d;
  logic               dividend_valid_q, dividend_valid_d;
  logic               cancelled_q, cancelled_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;

  logic               divisor_ready_s;
  logic               dividend_ready_s;
  logic               dout_valid_s;
  logic [2*WIDTH-1:0] dout_data_s;

  // Only the IP chosen at accept time is observed; the other one's handshakes are ignored.
  assign divisor_ready_s  = sel_q ? div_divisor_ready  : divu_divisor_ready;
  assign dividend_ready_s = sel_q ? div_dividend_ready : divu_dividend_ready;
  assign dout_valid_s     = sel_q ? div_dout_valid     : divu_dout_valid;
  assign dout_data_s      = sel_q ? div_dout_data      : divu_dout_data;

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    dividend_d       = dividend_q;
    divisor_d        = divisor_q;
    divisor_valid_d  = divisor_valid_q;
    dividend_valid_d = dividend_valid_q;
    cancelled_d      = cancelled_q;
    quotient_d       = quotient_q;
    remainder_d      = remainder_q;
    case (state_q)
      S_IDLE: begin
        if (req && !cancel) begin
          sel_d            = is_signed;
          dividend_d       = src_dividend;
          divisor_d        = src_divisor;
          divisor_valid_d  = 1'b1;
          dividend_valid_d = 1'b1;
          cancelled_d      = 1'b0;
          state_d          = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        cancelled_d      = cancelled_q | cancel;
        divisor_valid_d  = divisor_valid_q & ~divisor_ready_s;
        dividend_valid_d = dividend_valid_q & ~dividend_ready_s;
        if (!divisor_valid_d && !dividend_valid_d) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        cancelled_d = cancelled_q | cancel;
        if (dout_valid_s) begin
          // A cancel arriving together with dout_valid still suppresses delivery.
          if (cancelled_q || cancel) begin
            cancelled_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            quotient_d  = dout_data_s[2*WIDTH-1:WIDTH];
            remainder_d = dout_data_s[WIDTH-1:0];
            state_d     = S_DONE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SEND) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      sel_q            <= 1'b0;
      dividend_q       <= {WIDTH{1'b0}};
      divisor_q        <= {WIDTH{1'b0}};
      divisor_valid_q  <= 1'b0;
      dividend_valid_q <= 1'b0;
      cancelled_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      quotient_q       <= {WIDTH{1'b0}};
      remainder_q      <= {WIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      dividend_q       <= dividend_d;
      divisor_q        <= divisor_d;
      divisor_valid_q  <= divisor_valid_d;
      dividend_valid_q <= dividend_valid_d;
      cancelled_q      <= cancelled_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      quotient_q       <= quotient_d;
      remainder_q      <= remainder_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign quotient            = quotient_q;
  assign remainder           = remainder_q;
  assign div_divisor_data    = divisor_q;
  assign div_dividend_data   = dividend_q;
  assign divu_divisor_data   = divisor_q;
  assign divu_dividend_data  = dividend_q;
  assign div_divisor_valid   = sel_q & divisor_valid_q;
  assign div_dividend_valid  = sel_q & dividend_valid_q;
  assign divu_divisor_valid  = ~sel_q & divisor_valid_q;
  assign divu_dividend_valid = ~sel_q & dividend_valid_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl; the divider IPs are modelled by hand-driven handshakes.
module tb_div_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, req, is_signed, cancel;
  logic [W-1:0] src_dividend, src_divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic [W-1:0] div_divisor_data, div_dividend_data, divu_divisor_data, divu_dividend_data;
  logic         div_divisor_valid, div_dividend_valid, divu_divisor_valid, divu_dividend_valid;
  logic         div_divisor_ready, div_dividend_ready, divu_divisor_ready, divu_dividend_ready;
  logic         div_dout_valid, divu_dout_valid;
  logic [2*W-1:0] div_dout_data, divu_dout_data;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_div_dvs = 0, n_div_dvd = 0, n_divu_dvs = 0, n_divu_dvd = 0;
  int b_done, b_div_dvs, b_div_dvd, b_divu_dvs, b_divu_dvd;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .req(req), .is_signed(is_signed),
    .src_dividend(src_dividend), .src_divisor(src_divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_divisor_data(div_divisor_data), .div_dividend_data(div_dividend_data),
    .div_divisor_valid(div_divisor_valid), .div_dividend_valid(div_dividend_valid),
    .div_divisor_ready(div_divisor_ready), .div_dividend_ready(div_dividend_ready),
    .div_dout_valid(div_dout_valid), .div_dout_data(div_dout_data),
    .divu_divisor_data(divu_divisor_data), .divu_dividend_data(divu_dividend_data),
    .divu_divisor_valid(divu_divisor_valid), .divu_dividend_valid(divu_dividend_valid),
    .divu_divisor_ready(divu_divisor_ready), .divu_dividend_ready(divu_dividend_ready),
    .divu_dout_valid(divu_dout_valid), .divu_dout_data(divu_dout_data)
  );

  // Cycle counters for pulses and valids, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) n_done++;
    if (div_divisor_valid) n_div_dvs++;
    if (div_dividend_valid) n_div_dvd++;
    if (divu_divisor_valid) n_divu_dvs++;
    if (divu_dividend_valid) n_divu_dvd++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_done = n_done; b_div_dvs = n_div_dvs; b_div_dvd = n_div_dvd;
    b_divu_dvs = n_divu_dvs; b_divu_dvd = n_divu_dvd;
  endtask

  task automatic set_ready(input logic v);
    div_divisor_ready = v; div_dividend_ready = v;
    divu_divisor_ready = v; divu_dividend_ready = v;
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    src_dividend = 32'd0; src_divisor = 32'd0;
    set_ready(1'b0);
    div_dout_valid = 1'b0; divu_dout_valid = 1'b0;
    div_dout_data = 64'd0; divu_dout_data = 64'd0;
    tick(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_valids", {div_divisor_valid, div_dividend_valid, divu_divisor_valid, divu_dividend_valid}, 4'b0000);
    resetn = 1'b1;
    tick(1);

    // Unsigned basic: 100 / 7
    snap();
    set_ready(1'b1);
    req = 1'b1; is_signed = 1'b0; src_dividend = 32'd100; src_divisor = 32'd7;
    tick(1);
    check("u_busy_send", busy, 1'b1);
    check("u_valids", {divu_divisor_valid, divu_dividend_valid}, 2'b11);
    check("u_data", {divu_divisor_data, divu_dividend_data}, {32'd7, 32'd100});
    tick(1);
    check("u_valids_drop", {divu_divisor_valid, divu_dividend_valid}, 2'b00);
    check("u_busy_wait", busy, 1'b1);
    tick(3);
    divu_dout_valid = 1'b1; divu_dout_data = {32'd14, 32'd2};
    tick(1);
    divu_dout_valid = 1'b0; req = 1'b0;
    check("u_done", done, 1'b1);
    check("u_busy_done", busy, 1'b0);
    check("u_quot", quotient, 32'd14);
    check("u_rem", remainder, 32'd2);
    tick(1);
    check("u_done_drop", done, 1'b0);
    check("u_done_cnt", n_done - b_done, 32'd1);
    check("u_divu_vcnt", {n_divu_dvs - b_divu_dvs, n_divu_dvd - b_divu_dvd}, {32'd1, 32'd1});
    check("u_div_vcnt", {n_div_dvs - b_div_dvs, n_div_dvd - b_div_dvd}, 64'd0);

    // Signed: -7 / 2
    snap();
    req = 1'b1; is_signed = 1'b1; src_dividend = 32'hFFFF_FFF9; src_divisor = 32'd2;
    tick(2);
    div_dout_valid = 1'b1; div_dout_data = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tick(1);
    div_dout_valid = 1'b0; req = 1'b0;
    check("s_done", done, 1'b1);
    check("s_quot", quotient, 32'hFFFF_FFFD);
    check("s_rem", remainder, 32'hFFFF_FFFF);
    tick(1);
    check("s_div_vcnt", {n_div_dvs - b_div_dvs, n_div_dvd - b_div_dvd}, {32'd1, 32'd1});
    check("s_divu_vcnt", {n_divu_dvs - b_divu_dvs, n_divu_dvd - b_divu_dvd}, 64'd0);

    // Staggered readies: dividend accepted at once, divisor after a delay; early dout ignored.
    snap();
    divu_divisor_ready = 1'b0; divu_dividend_ready = 1'b1;
    req = 1'b1; is_signed = 1'b0; src_dividend = 32'd26; src_divisor = 32'd7;
    tick(1);
    src_dividend = 32'd0; src_divisor = 32'd0;
    tick(1);
    check("st_dvd_drop", {divu_divisor_valid, divu_dividend_valid}, 2'b10);
    divu_dout_valid = 1'b1; divu_dout_data = {32'd77, 32'd77};
    tick(1);
    divu_dout_valid = 1'b0;
    check("st_no_early_done", done, 1'b0);
    tick(1);
    check("st_dvs_data", divu_divisor_data, 32'd7);
    divu_divisor_ready = 1'b1;
    tick(1);
    check("st_dvs_drop", divu_divisor_valid, 1'b0);
    divu_dout_valid = 1'b1; divu_dout_data = {32'd3, 32'd5};
    tick(1);
    divu_dout_valid = 1'b0; req = 1'b0;
    check("st_done", done, 1'b1);
    check("st_result", {quotient, remainder}, {32'd3, 32'd5});
    tick(1);
    check("st_vcnt", {n_divu_dvs - b_divu_dvs, n_divu_dvd - b_divu_dvd}, {32'd4, 32'd1});

    // Cancel in WAIT
    snap();
    set_ready(1'b1);
    req = 1'b1; is_signed = 1'b0; src_dividend = 32'd50; src_divisor = 32'd3;
    tick(2);
    cancel = 1'b1; req = 1'b0;
    tick(1);
    cancel = 1'b0;
    check("cw_busy", busy, 1'b1);
    tick(1);
    divu_dout_valid = 1'b1; divu_dout_data = {32'd99, 32'd99};
    tick(1);
    divu_dout_valid = 1'b0;
    check("cw_busy_drop", busy, 1'b0);
    check("cw_no_done", done, 1'b0);
    check("cw_result_kept", {quotient, remainder}, {32'd3, 32'd5});
    tick(1);
    check("cw_done_cnt", n_done - b_done, 32'd0);

    // Cancel in SEND with ready low: valids held until accepted, then drain.
    snap();
    set_ready(1'b0);
    req = 1'b1; is_signed = 1'b1; src_dividend = 32'd40; src_divisor = 32'd8;
    tick(1);
    cancel = 1'b1; req = 1'b0;
    tick(1);
    cancel = 1'b0;
    tick(2);
    check("cs_valids_held", {div_divisor_valid, div_dividend_valid}, 2'b11);
    check("cs_busy", busy, 1'b1);
    set_ready(1'b1);
    tick(1);
    check("cs_valids_drop", {div_divisor_valid, div_dividend_valid}, 2'b00);
    div_dout_valid = 1'b1; div_dout_data = {32'd5, 32'd0};
    tick(1);
    div_dout_valid = 1'b0;
    check("cs_busy_drop", busy, 1'b0);
    check("cs_result_kept", {quotient, remainder}, {32'd3, 32'd5});
    tick(1);
    check("cs_done_cnt", n_done - b_done, 32'd0);

    // Back-to-back: req held through DONE, second op starts from IDLE.
    snap();
    req = 1'b1; is_signed = 1'b1; src_dividend = 32'd50; src_divisor = 32'd5;
    tick(2);
    div_dout_valid = 1'b1; div_dout_data = {32'd10, 32'd0};
    tick(1);
    div_dout_valid = 1'b0;
    check("bb1_done", done, 1'b1);
    check("bb1_result", {quotient, remainder}, {32'd10, 32'd0});
    is_signed = 1'b0; src_dividend = 32'd9; src_divisor = 32'd4;
    tick(1);
    check("bb_idle_busy", busy, 1'b0);
    check("bb_idle_done", done, 1'b0);
    tick(1);
    check("bb2_valids", {divu_divisor_valid, divu_dividend_valid}, 2'b11);
    check("bb2_data", {divu_divisor_data, divu_dividend_data}, {32'd4, 32'd9});
    tick(1);
    divu_dout_valid = 1'b1; divu_dout_data = {32'd2, 32'd1};
    tick(1);
    divu_dout_valid = 1'b0; req = 1'b0;
    check("bb2_done", done, 1'b1);
    check("bb2_result", {quotient, remainder}, {32'd2, 32'd1});
    tick(2);
    check("bb_done_cnt", n_done - b_done, 32'd2);

    // Reset mid-SEND, then a stray dout_valid
    snap();
    set_ready(1'b0);
    req = 1'b1; is_signed = 1'b0; src_dividend = 32'd11; src_divisor = 32'd2;
    tick(1);
    check("rs_send", busy, 1'b1);
    resetn = 1'b0; req = 1'b0;
    tick(1);
    check("rs_busy", busy, 1'b0);
    check("rs_valids", {div_divisor_valid, div_dividend_valid, divu_divisor_valid, divu_dividend_valid}, 4'b0000);
    check("rs_result", {quotient, remainder}, 64'd0);
    resetn = 1'b1;
    divu_dout_valid = 1'b1; div_dout_valid = 1'b1; divu_dout_data = {32'd5, 32'd1};
    tick(1);
    divu_dout_valid = 1'b0; div_dout_valid = 1'b0;
    tick(1);
    check("rs_no_done", n_done - b_done, 32'd0);
    check("rs_idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
